// File: rtl/conv2d_sched_if.sv
// Weight-fetch and source-pixel handshake bundle for conv2d_sched.
// master = weight/pixel provider, slave = scheduler.
interface conv2d_sched_if #(
   parameter int KS = 3
);
   logic                  wt_req;
   logic                  wt_valid;
   logic [KS*KS*32-1:0]   wt_data;
   logic                  src_valid;
   logic                  src_ready;
   logic [31:0]           src_data;

   modport master (
      input  wt_req, src_ready,
      output wt_valid, wt_data, src_valid, src_data
   );

   modport slave (
      output wt_req, src_ready,
      input  wt_valid, wt_data, src_valid, src_data
   );
endinterface

// File: rtl/conv2d_sched.sv
// Per-channel LOAD/GAP/STREAM/DRAIN sequencer feeding a KSxKS convolution core.
// Define CONV2D_SCHED_STAT_EN to add the stat_cycles / stat_stall counters.
module conv2d_sched #(
   parameter int C_WIDTH = 9,
   parameter int C_CHAN  = 8,
   parameter int KS      = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   conv2d_sched_if.slave         bus,
   input  logic                  cmd_start,
   input  logic [C_WIDTH-1:0]    cfg_width,
   input  logic [C_WIDTH-1:0]    cfg_height,
   input  logic [C_CHAN-1:0]     cfg_chan,
   output logic                  param_ena,
   output logic [KS*KS*32-1:0]   param_weight,
   output logic [C_WIDTH-1:0]    param_width_in,
   output logic                  pxl_ena_x,
   output logic [31:0]           pxl_x,
   input  logic                  pxl_ena_y,
   output logic [31:0]           pxl_y,
   input  logic                  pxl_ena_z,
   input  logic [31:0]           pxl_z,
   output logic                  psum_rd,
   input  logic [31:0]           psum_rdata,
   output logic                  psum_wr,
   output logic [31:0]           psum_wdata,
   output logic                  out_valid,
   output logic [31:0]           out_data,
   output logic                  busy,
   output logic                  done,
   output logic                  err_underrun
`ifdef CONV2D_SCHED_STAT_EN
   ,
   output logic [31:0]           stat_cycles,
   output logic [31:0]           stat_stall
`endif
);
   localparam int PW = 2*C_WIDTH;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_GAP, S_STREAM, S_DRAIN, S_DONE} state_t;
   state_t state, state_nx;

   logic [C_WIDTH-1:0]  w_q, h_q;
   logic [C_CHAN-1:0]   chan_q, ch;
   logic [KS*KS*32-1:0] wt_q;
   logic [PW-1:0]       pix_cnt, z_cnt, pix_total, z_total;
   logic                err_q;
   logic                start_ok, load_ok, skip, last_ch, stream_end, drain_end, ch_adv, underrun;

   assign start_ok   = (state == S_IDLE) && cmd_start;
   assign load_ok    = (state == S_LOAD) && bus.wt_valid;
   assign skip       = (w_q < C_WIDTH'(3)) || (h_q < C_WIDTH'(3));
   assign last_ch    = (ch == chan_q - C_CHAN'(1));
   assign pix_total  = PW'(w_q) * PW'(h_q);
   // The core emits one z per pixel of every row from the third onward.
   assign z_total    = PW'(h_q - C_WIDTH'(2)) * PW'(w_q);
   assign stream_end = (state == S_STREAM) && (pix_cnt == pix_total - PW'(1));
   assign drain_end  = (state == S_DRAIN) && (z_cnt >= z_total);
   assign ch_adv     = ((load_ok && skip) || drain_end) && !last_ch;
   assign underrun   = pxl_ena_x && !bus.src_valid;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (cmd_start) state_nx = S_LOAD;
         S_LOAD:   if (bus.wt_valid) state_nx = skip ? (last_ch ? S_DONE : S_LOAD) : S_GAP;
         S_GAP:    state_nx = S_STREAM;
         S_STREAM: if (stream_end) state_nx = S_DRAIN;
         S_DRAIN:  if (drain_end) state_nx = last_ch ? S_DONE : S_LOAD;
         S_DONE:   state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      bus.wt_req    = 1'b0;
      bus.src_ready = 1'b0;
      param_ena     = 1'b0;
      pxl_ena_x     = 1'b0;
      busy          = 1'b1;
      done          = 1'b0;
      case (state)
         S_IDLE:   busy = 1'b0;
         S_LOAD:   begin bus.wt_req = 1'b1; param_ena = bus.wt_valid; end
         S_STREAM: begin pxl_ena_x = 1'b1; bus.src_ready = 1'b1; end
         S_DONE:   done = 1'b1;
         default:  ;
      endcase
   end

   assign param_weight   = param_ena ? bus.wt_data : wt_q;
   assign param_width_in = w_q;
   assign pxl_x          = (pxl_ena_x && bus.src_valid) ? bus.src_data : 32'd0;
   assign pxl_y          = (ch != '0) ? psum_rdata : 32'd0;
   assign psum_rd        = pxl_ena_y && (ch != '0);
   // Gating with busy keeps these quiet in IDLE and while reset is held.
   assign out_valid      = pxl_ena_z && busy && last_ch;
   assign psum_wr        = pxl_ena_z && busy && !last_ch;
   assign out_data       = out_valid ? pxl_z : 32'd0;
   assign psum_wdata     = psum_wr ? pxl_z : 32'd0;
   assign err_underrun   = err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         w_q     <= '0;
         h_q     <= '0;
         chan_q  <= '0;
         ch      <= '0;
         wt_q    <= '0;
         pix_cnt <= '0;
         z_cnt   <= '0;
         err_q   <= 1'b0;
      end else begin
         if (start_ok) begin
            w_q    <= cfg_width;
            h_q    <= cfg_height;
            chan_q <= (cfg_chan == '0) ? C_CHAN'(1) : cfg_chan;
            ch     <= '0;
            err_q  <= 1'b0;
         end else if (ch_adv) begin
            ch <= ch + C_CHAN'(1);
         end
         if (load_ok) wt_q <= bus.wt_data;
         if (state == S_GAP)         pix_cnt <= '0;
         else if (state == S_STREAM) pix_cnt <= pix_cnt + PW'(1);
         if (state == S_LOAD)        z_cnt <= '0;
         else if (pxl_ena_z)         z_cnt <= z_cnt + PW'(1);
         if (underrun) err_q <= 1'b1;
      end
   end

`ifdef CONV2D_SCHED_STAT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_cycles <= '0;
         stat_stall  <= '0;
      end else if (start_ok) begin
         stat_cycles <= '0;
         stat_stall  <= '0;
      end else begin
         if (busy)     stat_cycles <= stat_cycles + 32'd1;
         if (underrun) stat_stall  <= stat_stall + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_conv2d_sched.sv
// Scoreboard bench for conv2d_sched with a small behavioural conv core and psum FIFO.
module tb_conv2d_sched;
   localparam int CW = 9;
   localparam int CC = 8;
   localparam int KS = 3;
   localparam int WB = KS*KS*32;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   conv2d_sched_if #(.KS(KS)) bif();

   logic          cmd_start;
   logic [CW-1:0] cfg_width, cfg_height;
   logic [CC-1:0] cfg_chan;
   logic          param_ena;
   logic [WB-1:0] param_weight;
   logic [CW-1:0] param_width_in;
   logic          pxl_ena_x, pxl_ena_y, pxl_ena_z;
   logic [31:0]   pxl_x, pxl_y, pxl_z;
   logic          psum_rd, psum_wr, out_valid, busy, done, err_underrun;
   logic [31:0]   psum_rdata, psum_wdata, out_data;
`ifdef CONV2D_SCHED_STAT_EN
   logic [31:0]   stat_cycles, stat_stall;
`endif

   conv2d_sched #(.C_WIDTH(CW), .C_CHAN(CC), .KS(KS)) dut (
      .clk(clk), .rst(rst), .bus(bif),
      .cmd_start(cmd_start), .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_chan(cfg_chan),
      .param_ena(param_ena), .param_weight(param_weight), .param_width_in(param_width_in),
      .pxl_ena_x(pxl_ena_x), .pxl_x(pxl_x), .pxl_ena_y(pxl_ena_y), .pxl_y(pxl_y),
      .pxl_ena_z(pxl_ena_z), .pxl_z(pxl_z),
      .psum_rd(psum_rd), .psum_rdata(psum_rdata), .psum_wr(psum_wr), .psum_wdata(psum_wdata),
      .out_valid(out_valid), .out_data(out_data), .busy(busy), .done(done),
      .err_underrun(err_underrun)
`ifdef CONV2D_SCHED_STAT_EN
      , .stat_cycles(stat_cycles), .stat_stall(stat_stall)
`endif
   );

   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input logic [WB-1:0] act, input logic [WB-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Behavioural core: z for every pixel from row 2 on, z = x + partial sum (3-cycle latency).
   logic [CW-1:0] core_w;
   logic          core_prev, v1, v2, v3;
   int            core_idx;
   logic [31:0]   x1, x2, z3;
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         core_w <= '0; core_prev <= 1'b0; core_idx <= 0;
         v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0; x1 <= '0; x2 <= '0; z3 <= '0;
      end else begin
         if (param_ena) core_w <= param_width_in;
         core_prev <= pxl_ena_x;
         if (pxl_ena_x) core_idx <= core_prev ? core_idx + 1 : 1;
         v1 <= pxl_ena_x && ((core_prev ? core_idx : 0) >= 2*int'(core_w));
         x1 <= pxl_x;
         v2 <= v1;
         x2 <= x1;
         v3 <= v2;
         z3 <= x2 + pxl_y;
      end
   end
   assign pxl_ena_y = v2;
   assign pxl_ena_z = v3;
   assign pxl_z     = z3;

   // Partial-sum buffer modelled as a FIFO.
   logic [31:0] psum_mem [0:1023];
   logic [9:0]  wp, rp;
   assign psum_rdata = psum_mem[rp];
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp <= '0; rp <= '0;
      end else begin
         if (psum_wr) begin psum_mem[wp] <= psum_wdata; wp <= wp + 10'd1; end
         if (psum_rd) rp <= rp + 10'd1;
      end
   end

   logic [31:0] pix_mem [0:4095];
   bit          drop_mem [0:4095];
   int          sp = 0;
   int          wt_wait = 0;
   logic [WB-1:0] exp_wt [$];
   logic [31:0]   exp_q [$];

   // Stimulus driver: weights on request, pixels whenever the DUT accepts.
   initial begin
      bif.wt_valid = 1'b0; bif.wt_data = '0; bif.src_valid = 1'b0; bif.src_data = '0;
      forever begin
         @(posedge clk); #1;
         if (bif.wt_req && wt_wait == 0) begin
            for (int k = 0; k < KS*KS; k++) bif.wt_data[k*32 +: 32] = $urandom;
            bif.wt_valid = 1'b1;
            exp_wt.push_back(bif.wt_data);
            wt_wait = $urandom_range(0, 2);
         end else begin
            bif.wt_valid = 1'b0;
            if (bif.wt_req && wt_wait > 0) wt_wait--;
         end
         if (bif.src_ready && sp < 4096) begin
            bif.src_valid = !drop_mem[sp];
            bif.src_data  = drop_mem[sp] ? $urandom : pix_mem[sp];
            sp++;
         end else begin
            bif.src_valid = 1'($urandom_range(0, 1));
            bif.src_data  = $urandom;
         end
      end
   end

   int cyc = 0, t_param = 0, run = 0;
   int n_param, n_x, n_out, n_rd, n_rd0, n_done;
   int n_wr_ch [0:15];
   int cur_w = 0, cur_h = 0;
   bit prev_x = 1'b0;

   // Monitor: pops the scoreboard on every presented output.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst) begin
            prev_x = 1'b0;
            run = 0;
         end else begin
            if (param_ena) begin
               n_param++;
               t_param = cyc;
               chk("param_width_in", param_width_in, cur_w);
               if (exp_wt.size() == 0) chk("param_ena_unexpected", 1, 0);
               else chk("param_weight", param_weight, exp_wt.pop_front());
            end
            if (pxl_ena_x) begin
               if (!prev_x) chk("gap_cycles", cyc - t_param, 2);
               run++;
               n_x++;
               chk("pxl_x", pxl_x, bif.src_valid ? bif.src_data : 32'd0);
            end else if (prev_x) begin
               chk("stream_len", run, cur_w*cur_h);
               run = 0;
            end
            prev_x = pxl_ena_x;
            if (out_valid) begin
               n_out++;
               if (exp_q.size() == 0) chk("out_valid_unexpected", 1, 0);
               else chk("out_data", out_data, exp_q.pop_front());
            end
            if (psum_wr && n_param > 0 && n_param <= 16) n_wr_ch[n_param-1]++;
            if (psum_rd) begin
               n_rd++;
               if (n_param == 1) n_rd0++;
            end
            if (done) n_done++;
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_wt_req"}, bif.wt_req, 0);
      chk({tag, "_src_ready"}, bif.src_ready, 0);
      chk({tag, "_param_ena"}, param_ena, 0);
      chk({tag, "_param_weight"}, param_weight, 0);
      chk({tag, "_param_width_in"}, param_width_in, 0);
      chk({tag, "_pxl_ena_x"}, pxl_ena_x, 0);
      chk({tag, "_pxl_x"}, pxl_x, 0);
      chk({tag, "_pxl_y"}, pxl_y, 0);
      chk({tag, "_psum_rd"}, psum_rd, 0);
      chk({tag, "_psum_wr"}, psum_wr, 0);
      chk({tag, "_psum_wdata"}, psum_wdata, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_out_data"}, out_data, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err_underrun"}, err_underrun, 0);
   endtask

   task automatic run_job(input int w, input int h, input int c, input int drop_at,
                          input int rst_at, input bit spur);
      int ce, npix, nz, tmo, idx;
      bit skp;
      logic [31:0] s;
      ce   = (c == 0) ? 1 : c;
      npix = w*h;
      skp  = (w < 3) || (h < 3);
      nz   = skp ? 0 : (h-2)*w;
      for (int i = 0; i < ce*npix; i++) begin
         pix_mem[i]  = $urandom;
         drop_mem[i] = (i == drop_at);
      end
      sp = 0; n_param = 0; n_x = 0; n_out = 0; n_rd = 0; n_rd0 = 0; n_done = 0;
      for (int k = 0; k < 16; k++) n_wr_ch[k] = 0;
      cur_w = w; cur_h = h;
      if (rst_at < 0) begin
         for (int j = 0; j < nz; j++) begin
            s = 32'd0;
            for (int k = 0; k < ce; k++) begin
               idx = k*npix + 2*w + j;
               if (!drop_mem[idx]) s = s + pix_mem[idx];
            end
            exp_q.push_back(s);
         end
      end
      @(posedge clk); #1;
      cfg_width = CW'(w); cfg_height = CW'(h); cfg_chan = CC'(c); cmd_start = 1'b1;
      @(posedge clk); #1;
      cmd_start = 1'b0;
      cfg_width = CW'($urandom); cfg_height = CW'($urandom); cfg_chan = CC'($urandom);
      @(negedge clk);
      chk("busy_after_start", busy, 1);
      chk("err_cleared_on_start", err_underrun, 0);
      if (spur) begin
         tmo = 0;
         while (n_param < 1 && tmo < 1000) begin @(posedge clk); tmo++; end
         #1;
         cfg_width = CW'(5); cfg_height = CW'(5); cfg_chan = CC'(1); cmd_start = 1'b1;
         @(posedge clk); #1;
         cmd_start = 1'b0;
      end
      if (rst_at >= 0) begin
         tmo = 0;
         while (sp != rst_at + 1 && tmo < 2000) begin @(posedge clk); #2; tmo++; end
         chk("reached_reset_pixel", sp, rst_at + 1);
         rst = 1'b0;
         @(negedge clk);
         check_reset_outputs("midreset");
         repeat (2) @(posedge clk);
         #2;
         rst = 1'b1;
         exp_q.delete();
         exp_wt.delete();
         return;
      end
      tmo = 0;
      while (!done && tmo < 5000) begin @(negedge clk); tmo++; end
      chk("done_seen", done, 1);
      chk("err_underrun_at_done", err_underrun, (drop_at >= 0) ? 1 : 0);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("idle_not_busy", busy, 0);
      chk("param_ena_count", n_param, ce);
      chk("pxl_ena_x_count", n_x, skp ? 0 : ce*npix);
      chk("out_valid_count", n_out, nz);
      chk("done_count", n_done, 1);
      for (int k = 0; k < ce; k++) chk("psum_wr_count", n_wr_ch[k], (k < ce-1) ? nz : 0);
      chk("psum_rd_ch0", n_rd0, 0);
      chk("psum_rd_count", n_rd, (ce-1)*nz);
      chk("scoreboard_empty", exp_q.size(), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int w, h, c, d;
      cmd_start = 1'b0; cfg_width = '0; cfg_height = '0; cfg_chan = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk); #2;
      rst = 1'b1;
      run_job(5, 5, 1, -1, -1, 1'b0);
      run_job(4, 4, 3, -1, -1, 1'b0);
      run_job(5, 5, 1, 7, -1, 1'b0);
      run_job(5, 5, 2, -1, 10, 1'b0);
      run_job(5, 5, 2, -1, -1, 1'b0);
      run_job(6, 2, 3, -1, -1, 1'b1);
      run_job(2, 4, 1, -1, -1, 1'b0);
      run_job(3, 3, 0, -1, -1, 1'b0);
      for (int r = 0; r < 5; r++) begin
         w = $urandom_range(3, 7);
         h = $urandom_range(3, 7);
         c = $urandom_range(1, 3);
         d = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, c*w*h - 1)) : -1;
         run_job(w, h, c, d, -1, 1'b0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/conv2d_sched.md
CONV2D_SCHED -- requirements
Module: conv2d_sched

Interface
REQ-001 SHALL have parameter C_WIDTH, default 9, bit width of the frame width/height fields.
REQ-002 SHALL have parameter C_CHAN, default 8, bit width of the input-channel count.
REQ-003 SHALL have parameter KS, default 3, kernel size; weight bus is KS*KS*32 bits.
REQ-004 SHALL have one clock and one reset: clk  in  1  sole clock; rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: cmd_start  in  1  start pulse; cfg_width, cfg_height  in  C_WIDTH  frame size; cfg_chan  in  C_CHAN  input channels (0 treated as 1).
REQ-006 SHALL have ports: wt_req  out  1; wt_valid  in  1; wt_data  in  KS*KS*32  per-channel kernel.
REQ-007 SHALL have ports: src_valid  in  1; src_ready  out  1; src_data  in  32  input pixel stream.
REQ-008 SHALL have core-side ports: param_ena out 1; param_weight out KS*KS*32; param_width_in out C_WIDTH; pxl_ena_x out 1; pxl_x out 32; pxl_ena_y in 1; pxl_y out 32; pxl_ena_z in 1; pxl_z in 32.
REQ-009 SHALL have ports: psum_rd out 1; psum_rdata in 32; psum_wr out 1; psum_wdata out 32; out_valid out 1; out_data out 32; busy out 1; done out 1; err_underrun out 1.

Function
REQ-010 SHALL implement states IDLE, LOAD, GAP, STREAM, DRAIN, DONE.
REQ-011 IDLE: cmd_start latches cfg_*, clears channel index ch and err_underrun, and moves to LOAD; cmd_start outside IDLE is ignored.
REQ-012 LOAD: wt_req held high until wt_valid; on that cycle wt_data is captured, param_ena pulses for one cycle with param_weight=wt_data and param_width_in=cfg_width, and the state moves to GAP.
REQ-013 GAP: lasts exactly 1 cycle with pxl_ena_x=0 so the core sees a rising edge of pxl_ena_x, then moves to STREAM.
REQ-014 STREAM: pxl_ena_x=1 and src_ready=1 for exactly cfg_width*cfg_height consecutive cycles; pxl_x=src_data.
REQ-015 If src_valid=0 during a STREAM cycle, pxl_ena_x SHALL stay high, pxl_x SHALL be 0, and err_underrun SHALL set (sticky until next accepted cmd_start).
REQ-016 DRAIN: entered after the last STREAM cycle; leaves when the pxl_ena_z count for the channel reaches (cfg_height-2)*cfg_width.
REQ-017 On DRAIN exit: if ch < cfg_chan-1, increment ch and go to LOAD; otherwise go to DONE.
REQ-018 DONE: done=1 for one cycle, then IDLE.
REQ-019 pxl_y SHALL be 0 when ch==0, else psum_rdata; psum_rd = pxl_ena_y && ch!=0.
REQ-020 On pxl_ena_z: if ch is the last channel, out_valid=1 and out_data=pxl_z; otherwise psum_wr=1 and psum_wdata=pxl_z. Both are combinational from pxl_ena_z.
REQ-021 Pixel and output counters SHALL be 2*C_WIDTH bits wide and SHALL NOT wrap for legal configurations.
REQ-022 cfg_height<3 or cfg_width<3 SHALL skip STREAM/DRAIN for every channel; done still pulses.
REQ-023 busy=1 in every state except IDLE.

Reset
REQ-024 While rst=0: state=IDLE; all counters 0; wt_req, param_ena, pxl_ena_x, src_ready, psum_rd, psum_wr, out_valid, done, busy, err_underrun = 0; param_weight, param_width_in, pxl_x, pxl_y, psum_wdata, out_data = 0.
REQ-025 Reset asserted mid-frame SHALL abort immediately; after release, the core is re-primed only through LOAD (param_ena).

Configuration
REQ-026 With CONV2D_SCHED_STAT_EN defined, SHALL add outputs stat_cycles (32 bits, cycles spent in non-IDLE states of the last run) and stat_stall (32 bits, count of underrun cycles); both clear on an accepted cmd_start.
REQ-027 Without CONV2D_SCHED_STAT_EN, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-028 W=5,H=5,chan=1, wt_valid immediate, src always valid -> param_ena 1 pulse, then 1 GAP cycle, then 25 contiguous pxl_ena_x, 15 out_valid, done 1 pulse, psum_wr never.
REQ-029 W=4,H=4,chan=3 -> 3 param_ena pulses; psum_wr 8 per channel on ch 0 and 1; out_valid 8 on ch 2; psum_rd never on ch 0.
REQ-030 src_valid=0 on pixel 7 of 25 -> pxl_x=0 that cycle, pxl_ena_x stays high, err_underrun=1 through done, cleared by next cmd_start.
REQ-031 rst low at STREAM pixel 10 -> all outputs 0 next edge; next cmd_start restarts at LOAD with ch=0.
REQ-032 cfg_height=2 -> no pxl_ena_x; done pulses after cfg_chan LOADs; cmd_start while busy -> no effect.
